// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_stage_pkg                                             |
// | Purpose  : Shared funct3 codes, FSM state type and access-size       |
// |            helpers for the handshaked memory stage.                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } mem_st_e;

  // log2 of the access size in bytes; the RV64-only codes fall back to a word on RV32
  function automatic logic [1:0] size_log2(input logic [2:0] funct3, input logic is64);
    case (funct3)
      F3_B, F3_BU: size_log2 = 2'd0;
      F3_H, F3_HU: size_log2 = 2'd1;
      F3_D:        size_log2 = is64 ? 2'd3 : 2'd2;
      default:     size_log2 = 2'd2;
    endcase
  endfunction

  // Byte-enable pattern for the access size, before shifting to the lane offset
  function automatic logic [7:0] size_mask(input logic [2:0] funct3, input logic is64);
    case (size_log2(funct3, is64))
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access
  function automatic logic [2:0] align_mask(input logic [2:0] funct3, input logic is64);
    case (size_log2(funct3, is64))
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_hs_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : load_align                                                |
// | Purpose  : Extracts a byte/half/word/double from a full bus word at  |
// |            a lane offset and sign- or zero-extends it to XLEN.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module load_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]              rdata,
  input  logic [$clog2(XLEN/8)-1:0]    off,
  input  logic [2:0]                   funct3,
  output logic [XLEN-1:0]              data
);
  import mem_stage_pkg::*;

  localparam logic IS64 = (XLEN == 64);

  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_left;
  logic [1:0]      w_lg;
  logic [6:0]      w_pad;
  logic            w_signed;

  // Move the addressed lane to bit 0, park it at the MSB end, then shift back
  // arithmetically or logically to get the extension for free
  always_comb begin
    w_shifted = rdata >> {off, 3'b000};
    w_lg      = size_log2(funct3, IS64);
    w_pad     = 7'(XLEN) - (7'd8 << w_lg);
    w_signed  = ~funct3[2];
    w_left    = w_shifted << w_pad;
    data      = w_signed ? $unsigned($signed(w_left) >>> w_pad) : (w_left >> w_pad);
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_hs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_stage_hs                                              |
// | Purpose  : RV memory stage with req/gnt/rvalid data-memory port,     |
// |            lane steering, load extension, misalignment detection,    |
// |            pipeline stall and the MEM/WB register.                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module mem_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int NB     = XLEN / 8
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              valid_m,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [XLEN-1:0]   alu_result_m,
  input  logic [XLEN-1:0]   write_data_m,
  input  logic [XLEN-1:0]   pc_plus4_m,
  input  logic [2:0]        funct3_m,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic              reg_write_m,
  input  logic [1:0]        result_src_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [NB-1:0]     dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              stall_m,
  output logic              valid_w,
  output logic [REG_AW-1:0] rd_w,
  output logic [XLEN-1:0]   alu_result_w,
  output logic [XLEN-1:0]   read_data_w,
  output logic [XLEN-1:0]   pc_plus4_w,
  output logic              reg_write_w,
  output logic [1:0]        result_src_w,
  output logic              misalign_w
);

  localparam int   OFFW = $clog2(NB);
  localparam logic IS64 = (XLEN == 64);

  mem_st_e         r_state;
  mem_st_e         w_state_nxt;
  logic            w_acc;
  logic            w_mis;
  logic            w_go;
  logic            w_done;
  logic [OFFW-1:0] w_off;
  logic [1:0]      w_lg;
  logic [XLEN-1:0] w_load_data;

  // Access classification: a request only goes out for aligned memory ops
  always_comb begin
    w_off  = alu_result_m[OFFW-1:0];
    w_lg   = size_log2(funct3_m, IS64);
    w_acc  = valid_m & (mem_read_m | mem_write_m);
    w_mis  = w_acc & (|(alu_result_m[2:0] & align_mask(funct3_m, IS64)));
    w_go   = w_acc & ~w_mis;
    w_done = (r_state == WAIT_RSP) & dmem_rvalid;
  end

  // Bus fields come straight from the held MEM inputs, so they stay stable until grant
  always_comb begin
    dmem_we   = mem_write_m & w_go;
    dmem_addr = {alu_result_m[XLEN-1:OFFW], {OFFW{1'b0}}};
    dmem_be   = NB'(size_mask(funct3_m, IS64) << w_off);
    case (w_lg)
      2'd0:    dmem_wdata = {NB{write_data_m[7:0]}};
      2'd1:    dmem_wdata = {(NB/2){write_data_m[15:0]}};
      2'd2:    dmem_wdata = {(NB/4){write_data_m[31:0]}};
      default: dmem_wdata = write_data_m;
    endcase
    stall_m = w_go & ~w_done;
  end

  // Handshake state register; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (srst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and request: gnt only matters while req is high, rvalid only in WAIT_RSP
  always_comb begin
    w_state_nxt = r_state;
    dmem_req    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          dmem_req    = 1'b1;
          w_state_nxt = dmem_gnt ? WAIT_RSP : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        dmem_req = 1'b1;
        if (dmem_gnt) w_state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (dmem_rvalid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (dmem_rdata),
    .off    (w_off),
    .funct3 (funct3_m),
    .data   (w_load_data)
  );

  // MEM/WB register: bubbles while stalled, trap marker on misalignment, else capture.
  // A bubble also clears misalign_w so it can never raise a spurious trap.
  always_ff @(posedge clk) begin
    if (srst) begin
      valid_w      <= 1'b0;
      rd_w         <= '0;
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
      reg_write_w  <= 1'b0;
      result_src_w <= '0;
      misalign_w   <= 1'b0;
    end else if (stall_m) begin
      valid_w     <= 1'b0;
      reg_write_w <= 1'b0;
      misalign_w  <= 1'b0;
    end else begin
      rd_w         <= rd_m;
      alu_result_w <= alu_result_m;
      pc_plus4_w   <= pc_plus4_m;
      result_src_w <= result_src_m;
      if (w_mis) begin
        valid_w     <= 1'b1;
        misalign_w  <= 1'b1;
        reg_write_w <= 1'b0;
        read_data_w <= '0;
      end else begin
        valid_w     <= valid_m;
        misalign_w  <= 1'b0;
        reg_write_w <= reg_write_m & valid_m;
        read_data_w <= (mem_read_m & valid_m) ? w_load_data : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Parametrised successor to the single-cycle RV memory stage. Drives a decoupled data-memory port with a req/gnt/rvalid handshake, so multi-cycle and variable-latency memories are supported. Handles byte, half and word accesses (plus double accesses when XLEN=64) with byte enables and load sign/zero extension. Detects misaligned accesses, stalls the pipeline while an access is in flight, and registers the MEM/WB pipeline stage.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
REG_AW, 5, register-file address width.
NB, XLEN/8, byte lanes (derived; do not override).

Ports:
clk  in  1  clock
srst  in  1  synchronous reset, active-high
valid_m  in  1  MEM-stage instruction valid
rd_m  in  REG_AW  destination register
alu_result_m  in  XLEN  effective address or ALU result
write_data_m  in  XLEN  store data, lane 0 aligned
pc_plus4_m  in  XLEN  PC+4
funct3_m  in  3  access size and sign (RV encoding)
mem_read_m  in  1  load
mem_write_m  in  1  store
reg_write_m  in  1  register write enable
result_src_m  in  2  writeback mux select
dmem_req  out  1  request valid
dmem_we  out  1  write request
dmem_addr  out  XLEN  address, bits [log2(NB)-1:0] forced to 0
dmem_be  out  NB  byte enables
dmem_wdata  out  XLEN  lane-shifted store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  response valid (loads and stores)
dmem_rdata  in  XLEN  read data, full bus word
stall_m  out  1  hold IF..MEM stages
valid_w, rd_w, alu_result_w, read_data_w, pc_plus4_w, reg_write_w, result_src_w  out  1/REG_AW/XLEN/XLEN/XLEN/1/2  MEM/WB register
misalign_w  out  1  misaligned-access flag for the trap logic

Behaviour:
- Reset (synchronous, srst high at a clk edge): FSM goes to IDLE; all *_w outputs and misalign_w go to 0. srst mid-access abandons the transaction; any dmem_rvalid that arrives afterwards in IDLE is ignored.
- acc = valid_m & (mem_read_m | mem_write_m). mis = acc & address not aligned to the access size (half: a[0]; word: a[1:0]; double: a[2:0]).
- funct3 decode: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU. Codes 011 LD/SD and 110 LWU are legal only when XLEN=64; otherwise they are treated as a word access.
- FSM states:
  - IDLE: if acc & ~mis, assert dmem_req combinationally. On dmem_gnt go to WAIT_RSP; otherwise go to WAIT_GNT.
  - WAIT_GNT: hold dmem_req and all dmem_* outputs stable until dmem_gnt, then go to WAIT_RSP.
  - WAIT_RSP: dmem_req=0. On dmem_rvalid, capture into the W register and return to IDLE.
- dmem_gnt is ignored while dmem_req=0. Only one outstanding transaction is allowed.
- Minimum MEM occupancy for a memory access is 2 cycles (gnt in the request cycle, rvalid on the next).
- stall_m = acc & ~mis & ~(state==WAIT_RSP & dmem_rvalid). Upstream holds all *_m inputs stable while stall_m=1.
- W register update on every clk:
  - stall_m=1: insert a bubble (valid_w=0, reg_write_w=0; other fields don't-care but hold).
  - mis=1: valid_w=1, misalign_w=1, reg_write_w=0, no bus request, no stall.
  - Otherwise: capture the *_m fields; valid_w=valid_m; misalign_w=0; reg_write_w=reg_write_m & valid_m.
- Store lanes: off = a[log2(NB)-1:0]. dmem_be = size mask << off. dmem_wdata = write_data_m replicated across lanes.
- Load extract: read_data_w = (dmem_rdata >> 8*off), truncated to the access size, then sign- or zero-extended to XLEN. Non-load instructions capture 0 into read_data_w.
- If dmem_rvalid and dmem_gnt would coincide (not legal in WAIT_RSP), gnt is ignored.

Decomposition:
- Package mem_stage_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - typedef enum logic[1:0] {IDLE, WAIT_GNT, WAIT_RSP} mem_st_e;
  - function size_mask(funct3).
- One combinational sub-module, load_align (inputs rdata, off, funct3; output extended data), shared with future load/store units.

Test Plan:
1. XLEN=32, SW addr 0x104 data 0xDEADBEEF, gnt same cycle, rvalid next cycle -> be=4'hF, addr=0x104, stall_m high for 1 cycle, valid_w=1, reg_write_w=0.
2. LB addr 0x103, rdata=0x80FF_0000 -> read_data_w=0xFFFFFF80. LBU at the same address -> read_data_w=0x00000080. LH addr 0x102 -> 0xFFFF80FF.
3. SB addr 0x201 data 0xAB, gnt delayed 3 cycles -> dmem_req held 4 cycles with be=4'b0010, wdata=0xABABABAB; stall_m high until rvalid; W register shows bubbles during the stall.
4. LW addr 0x102 -> no dmem_req, stall_m=0, misalign_w=1, reg_write_w=0 next cycle.
5. srst asserted while in WAIT_RSP, stray rvalid arrives after reset -> state IDLE, all *_w=0, stall_m=0, rvalid ignored.
6. XLEN=64, LWU addr 0x14, rdata upper word 0x8000_0001 -> read_data_w=0x0000000080000001. SD addr 0x18 -> be=8'hFF.
